// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase enumeration for the intersection controller.
package traffic_pkg;
    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        A_GREEN = 3'd0,
        A_YEL   = 3'd1,
        A_CLR   = 3'd2,
        B_GREEN = 3'd3,
        B_YEL   = 3'd4,
        B_CLR   = 3'd5,
        WALK    = 3'd6
    } phase_t;
endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase counter; cleared synchronously whenever the phase changes.
module phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)       cnt_d = '0;
        else if (tick) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road timed phase controller with min/max green, yellow, all-red and
// optional pedestrian walk phase (enabled by TRAFFIC_PED_WALK_EN).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CW        = 8,
    parameter int GREEN_MIN = 20,
    parameter int MAX_GREEN = 60,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic [1:0] la,
    output logic [1:0] lb
);
    localparam logic [CW-1:0] GMIN_L = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_L = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_L  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] CLR_L  = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] WALK_L = CW'(WALK_T - 1);

    phase_t        state_q, state_d;
    logic          ped_pend_q, ped_pend_d;
    logic          dir_q, dir_d;
    logic          ped_ack_q, ped_ack_d;
    logic [CW-1:0] cnt;
    logic          enter_walk;

    phase_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .clr     (state_d != state_q),
        .cnt     (cnt)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (tick) begin
            case (state_q)
                A_GREEN: if ((cnt >= GMIN_L && (!ta || ped_pend_q)) || cnt == GMAX_L) state_d = A_YEL;
                A_YEL:   if (cnt == YEL_L) state_d = A_CLR;
                A_CLR:   if (cnt == CLR_L) begin
                    if (ped_pend_q) begin
                        state_d = WALK;
                        dir_d   = 1'b1;
                    end else begin
                        state_d = B_GREEN;
                    end
                end
                B_GREEN: if ((cnt >= GMIN_L && (!tb || ped_pend_q)) || cnt == GMAX_L) state_d = B_YEL;
                B_YEL:   if (cnt == YEL_L) state_d = B_CLR;
                B_CLR:   if (cnt == CLR_L) begin
                    if (ped_pend_q) begin
                        state_d = WALK;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = A_GREEN;
                    end
                end
                WALK:    if (cnt == WALK_L) state_d = dir_q ? B_GREEN : A_GREEN;
                default: state_d = A_GREEN;
            endcase
        end
    end

    assign enter_walk = (state_d == WALK) && (state_q != WALK);
    assign ped_ack_d  = enter_walk;

`ifdef TRAFFIC_PED_WALK_EN
    // A request arriving on the entry edge stays pending for the next round.
    assign ped_pend_d = ped_req | (ped_pend_q & ~enter_walk);
`else
    // Pending never sets, so WALK is unreachable and the exits reduce to !ta / !tb.
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
    assign ped_pend_d     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= A_GREEN;
            ped_pend_q <= 1'b0;
            dir_q      <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            dir_q      <= dir_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    always_comb begin
        la   = RED;
        lb   = RED;
        walk = 1'b0;
        case (state_q)
            A_GREEN: la = GREEN;
            A_YEL:   la = YELLOW;
            B_GREEN: lb = GREEN;
            B_YEL:   lb = YELLOW;
            WALK:    walk = 1'b1;
            default: ;
        endcase
    end

    assign ped_ack = ped_ack_q;
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

- Timed phase controller for a two-road intersection, lights A and B.
- Drives both light pairs from a tick-based phase counter.
- Enforces minimum and maximum green, yellow and all-red clearance intervals, and inserts a pedestrian walk phase on request.
- Sits between the free-running tick divider and the lamp drivers, replacing the untimed sensor-only sequencer.

## Interface
Parameters:
- CW, 8, phase counter width
- GREEN_MIN, 20, minimum green length in ticks (≥1)
- MAX_GREEN, 60, forced green limit in ticks (≥GREEN_MIN, <2^CW)
- YELLOW_T, 3, yellow length in ticks (≥1)
- ALLRED_T, 1, all-red clearance length in ticks (≥1)
- WALK_T, 10, walk phase length in ticks (≥1)

Ports:
- clk  in  1  single clock; one clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base enable; counters advance only when high
- ta  in  1  traffic present on road A
- tb  in  1  traffic present on road B
- ped_req  in  1  pedestrian request, sampled every cycle
- ped_ack  out  1  one-cycle pulse when the request is served
- walk  out  1  walk lamp
- la  out  2  road A light (green 00, yellow 01, red 10)
- lb  out  2  road B light, same encoding

## Operation
States and their outputs:
- A_GREEN: la=00, lb=10
- A_YEL: la=01, lb=10
- A_CLR: la=lb=10
- B_GREEN: lb=00, la=10
- B_YEL: lb=01, la=10
- B_CLR: la=lb=10
- WALK: la=lb=10, walk=1

Phase counter:
- Cleared to 0 on every state change.
- Increments on tick, otherwise holds.
- A phase of length T ends on the tick cycle where cnt==T-1, so it lasts exactly T ticks.

Transitions (evaluated only on tick cycles):
- A_GREEN→A_YEL when (cnt≥GREEN_MIN-1 and (!ta or ped_pend)) or cnt==MAX_GREEN-1.
- A_YEL→A_CLR after YELLOW_T.
- A_CLR→WALK if ped_pend, else →B_GREEN, after ALLRED_T. Entering WALK from A_CLR sets dir=1.
- B side mirrors A using tb. Entering WALK from B_CLR sets dir=0.
- WALK→B_GREEN if dir=1, else →A_GREEN, after WALK_T.

Pedestrian handshake:
- ped_req high on any cycle sets ped_pend.
- ped_ack pulses in the first cycle of WALK, and ped_pend clears at that same edge.
- ped_req high in the ack cycle or later during WALK re-arms ped_pend for the next round; the request is not lost.

Outputs:
- Moore decode of the state register.
- Reset values: state A_GREEN, cnt 0, la=00, lb=10, walk=0, ped_ack=0, ped_pend=0, dir=0.

## Timing
- Decision latency: a transition condition true on tick cycle t updates the state at the next rising edge; la, lb and walk change in cycle t+1.
- Minimum cycle, tick every cycle, with no traffic and no request: GREEN_MIN + YELLOW_T + ALLRED_T ticks per side.
- tick low: state and cnt hold, and ta/tb/ped_req changes do not move the state. ped_pend still latches.
- ta drops mid-green before GREEN_MIN: green continues to GREEN_MIN.
- ta held high: green is forced off at MAX_GREEN.
- reset_n low at any time, including mid-WALK or mid-yellow: all outputs take their reset values immediately, without waiting for clk. Operation resumes in A_GREEN on the first edge after release.

## Configuration
Macro TRAFFIC_PED_WALK_EN.
- Defined: WALK state, ped_pend, dir and the handshake behave as described above.
- Undefined:
  - The ped_req, ped_ack and walk ports remain; ped_ack=0 and walk=0 constantly.
  - ped_req is ignored.
  - A_CLR→B_GREEN and B_CLR→A_GREEN unconditionally.
  - The green exit term uses !ta (or !tb) only.

## Structure
- Package traffic_pkg holds:
  - the light encoding constants GREEN, YELLOW and RED;
  - the phase_t enum of the seven states, encoding fixed at 3 bits.
- One sub-module, phase_timer:
  - CW-bit counter with tick enable and synchronous clear on state change;
  - asynchronous clear on reset_n;
  - outputs the current count, compared in the parent against T-1.

## Test plan
Bench parameters for all tests except test 6: GREEN_MIN=2, MAX_GREEN=4, YELLOW_T=1, ALLRED_T=1, WALK_T=2, tick=1 every cycle.

1. Reset → la=00, lb=10, walk=0, ped_ack=0; after release, A_GREEN persists while ta=1.
2. ta=1, tb=0, no request → A green 4 cycles, A yellow 1, all-red 1, then lb=00; B green exits after 2 cycles since tb=0.
3. ta=0 from reset → la=00 for exactly 2 cycles, then la=01 for 1 cycle, then la=lb=10 for 1 cycle.
4. ped_req pulse in A_GREEN cycle 0 → A exits at 2 ticks; after A_CLR, walk=1 for 2 cycles with ped_ack high in the first of them; then lb=00, ped_pend=0.
5. reset_n driven low during the second WALK cycle → walk=0, la=00, lb=10 before the next clk edge; no ped_ack after release.
6. tick held low for 50 cycles in A_GREEN with ta=0 → state unchanged; the first tick then advances cnt by exactly 1.
